// File: rtl/frog_hopper_pkg.sv
// Shared definitions for the frog hopper: direction codes, FSM states and default geometry.
package frog_hopper_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        HOP  = 1'b1
    } state_e;

    localparam int unsigned DEF_CELL     = 32;
    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_SCREEN_H = 480;

    // Button vector bit order is {right, left, down, up}; up wins ties.
    function automatic logic [1:0] prio_dir(input logic [3:0] b);
        if (b[0]) begin
            return DIR_UP;
        end else if (b[1]) begin
            return DIR_DOWN;
        end else if (b[2]) begin
            return DIR_LEFT;
        end
        return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/frog_dir_arbiter.sv
// Turns debounced button levels into one-cycle hop requests: rising-edge presses plus
// hold-to-repeat after REPEAT_FRAMES frame ticks on the same highest-priority button.
module frog_dir_arbiter
    import frog_hopper_pkg::*;
#(
    parameter int unsigned REPEAT_FRAMES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    input  logic       clear,
    output logic       req_valid,
    output logic [1:0] req_dir
);

    localparam int unsigned CntW = (REPEAT_FRAMES < 1) ? 1 : $clog2(REPEAT_FRAMES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(REPEAT_FRAMES);

    logic [3:0]      btn_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      press;
    logic            same_held;
    logic            fire;

    always_comb begin
        press     = btn & ~btn_q;
        // The registered button copy doubles as last cycle's held direction.
        same_held = (|btn) && (|btn_q) && (prio_dir(btn) == prio_dir(btn_q));

        cnt_d = cnt_q;
        if (clear || !same_held) begin
            cnt_d = '0;
        end else if (frame_tick && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end

        fire      = same_held && (cnt_q == CntMax);
        req_valid = (|press) || fire;
        req_dir   = (|press) ? prio_dir(press) : prio_dir(btn);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= '0;
            cnt_q <= '0;
        end else begin
            btn_q <= btn;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frog_hopper.sv
// Grid-locked frog movement with per-frame hop animation, bounds, respawn and new-row pulses.
// Define FROG_WRAP_EN to let horizontal hops leave the playfield and wrap to the far edge.
module frog_hopper
    import frog_hopper_pkg::*;
#(
    parameter int unsigned CELL          = DEF_CELL,
    parameter int unsigned STEP          = 8,
    parameter int unsigned SCREEN_W      = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H      = DEF_SCREEN_H,
    parameter int unsigned START_X       = 320,
    parameter int unsigned START_Y       = 448,
    parameter int unsigned COORD_W       = 10,
    parameter int unsigned REPEAT_FRAMES = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               respawn,
    output logic [COORD_W-1:0] frog_x,
    output logic [COORD_W-1:0] frog_y,
    output logic [1:0]         facing,
    output logic               busy,
    output logic               hop_done,
    output logic               new_row
);

    // One extra sign bit so targets below zero and off-edge animation are representable.
    typedef logic signed [COORD_W:0] coord_t;

    localparam coord_t CellC   = coord_t'(CELL);
    localparam coord_t StepC   = coord_t'(STEP);
    localparam coord_t MaxX    = coord_t'(SCREEN_W - CELL);
    localparam coord_t MaxY    = coord_t'(SCREEN_H - CELL);
    localparam coord_t StartX  = coord_t'(START_X);
    localparam coord_t StartY  = coord_t'(START_Y);
    localparam coord_t ScreenW = coord_t'(SCREEN_W);
    localparam coord_t Zero    = coord_t'(0);

    state_e     state_q, state_d;
    coord_t     x_q, x_d, y_q, y_d;
    coord_t     tx_q, tx_d, ty_q, ty_d;
    coord_t     best_q, best_d;
    logic [1:0] facing_q, facing_d;
    logic       hop_done_q, hop_done_d;
    logic       new_row_q, new_row_d;

    logic       req_valid;
    logic [1:0] req_dir;
    logic       clear;
    coord_t     cand_x, cand_y, step_x, step_y;
    logic       x_ok, y_ok;

    frog_dir_arbiter #(
        .REPEAT_FRAMES(REPEAT_FRAMES)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn       ({btn_right, btn_left, btn_down, btn_up}),
        .clear     (clear),
        .req_valid (req_valid),
        .req_dir   (req_dir)
    );

    always_comb begin
        cand_x = x_q;
        cand_y = y_q;
        unique case (req_dir)
            DIR_UP:    cand_y = y_q - CellC;
            DIR_DOWN:  cand_y = y_q + CellC;
            DIR_LEFT:  cand_x = x_q - CellC;
            DIR_RIGHT: cand_x = x_q + CellC;
        endcase

        y_ok = (cand_y >= Zero) && (cand_y <= MaxY);
`ifdef FROG_WRAP_EN
        x_ok = 1'b1;
`else
        x_ok = (cand_x >= Zero) && (cand_x <= MaxX);
`endif

        step_x = x_q;
        step_y = y_q;
        if (x_q != tx_q) begin
            step_x = (tx_q > x_q) ? x_q + StepC : x_q - StepC;
        end
        if (y_q != ty_q) begin
            step_y = (ty_q > y_q) ? y_q + StepC : y_q - StepC;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        best_d     = best_q;
        facing_d   = facing_q;
        hop_done_d = 1'b0;
        new_row_d  = 1'b0;
        clear      = 1'b0;

        if (respawn) begin
            state_d = IDLE;
            x_d     = StartX;
            y_d     = StartY;
            tx_d    = StartX;
            ty_d    = StartY;
            best_d  = StartY;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && x_ok && y_ok) begin
                        tx_d     = cand_x;
                        ty_d     = cand_y;
                        facing_d = req_dir;
                        state_d  = HOP;
                        clear    = 1'b1;
                    end
                end
                HOP: begin
                    if (frame_tick) begin
                        x_d = step_x;
                        y_d = step_y;
                        if ((step_x == tx_q) && (step_y == ty_q)) begin
                            state_d    = IDLE;
                            hop_done_d = 1'b1;
                            if (step_y < best_q) begin
                                best_d    = step_y;
                                new_row_d = 1'b1;
                            end
`ifdef FROG_WRAP_EN
                            if (step_x == -CellC) begin
                                x_d = MaxX;
                            end else if (step_x == ScreenW) begin
                                x_d = Zero;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= StartX;
            y_q        <= StartY;
            tx_q       <= StartX;
            ty_q       <= StartY;
            best_q     <= StartY;
            facing_q   <= DIR_UP;
            hop_done_q <= 1'b0;
            new_row_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            best_q     <= best_d;
            facing_q   <= facing_d;
            hop_done_q <= hop_done_d;
            new_row_q  <= new_row_d;
        end
    end

    assign frog_x   = x_q[COORD_W-1:0];
    assign frog_y   = y_q[COORD_W-1:0];
    assign facing   = facing_q;
    assign busy     = (state_q == HOP);
    assign hop_done = hop_done_q;
    assign new_row  = new_row_q;

endmodule

// File: tb/tb_frog_hopper.sv
// Directed self-checking bench for frog_hopper at default parameters.
module tb_frog_hopper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       respawn = 1'b0;
    logic [9:0] frog_x, frog_y;
    logic [1:0] facing;
    logic       busy, hop_done, new_row;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frog_hopper dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .respawn   (respawn),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .facing    (facing),
        .busy      (busy),
        .hop_done  (hop_done),
        .new_row   (new_row)
    );

    task automatic set_btns(input logic [3:0] b);  // {right, left, down, up}
        btn_up    = b[0];
        btn_down  = b[1];
        btn_left  = b[2];
        btn_right = b[3];
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge clk) set_btns(b);
        @(negedge clk) set_btns(4'b0000);
    endtask

    task automatic hop(input logic [3:0] b);
        press(b);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (frog_x !== 10'd320 || frog_y !== 10'd448) begin
            n_fail++;
            $display("FAIL reset_pos got %0d,%0d expected 320,448", frog_x, frog_y);
        end
        n_checks++;
        if ({facing, busy, hop_done, new_row} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags got facing=%0d busy=%b done=%b row=%b expected 0,0,0,0",
                     facing, busy, hop_done, new_row);
        end
        reset = 1'b0;
    endtask

    task automatic test_up_hop();
        press(4'b0001);
        n_checks++;
        if (busy !== 1'b1 || facing !== 2'd0 || frog_y !== 10'd448) begin
            n_fail++;
            $display("FAIL up_accept got busy=%b facing=%0d y=%0d expected 1,0,448",
                     busy, facing, frog_y);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (frog_y !== 10'(448 - 8 * i) || frog_x !== 10'd320) begin
                n_fail++;
                $display("FAIL up_tick%0d got %0d,%0d expected 320,%0d", i, frog_x, frog_y,
                         448 - 8 * i);
            end
            n_checks++;
            if (hop_done !== (i == 4) || new_row !== (i == 4) || busy !== (i < 4)) begin
                n_fail++;
                $display("FAIL up_flags%0d got done=%b row=%b busy=%b expected %b,%b,%b", i,
                         hop_done, new_row, busy, i == 4, i == 4, i < 4);
            end
        end
        @(negedge clk);
        n_checks++;
        if (hop_done !== 1'b0 || new_row !== 1'b0) begin
            n_fail++;
            $display("FAIL up_pulse_width got done=%b row=%b expected 0,0", hop_done, new_row);
        end
    endtask

    task automatic test_new_row_respawn();
        hop(4'b0010);
        n_checks++;
        if (frog_y !== 10'd448 || hop_done !== 1'b1 || new_row !== 1'b0 || facing !== 2'd1) begin
            n_fail++;
            $display("FAIL down_land got y=%0d done=%b row=%b facing=%0d expected 448,1,0,1",
                     frog_y, hop_done, new_row, facing);
        end
        hop(4'b0001);
        n_checks++;
        if (frog_y !== 10'd416 || hop_done !== 1'b1 || new_row !== 1'b0) begin
            n_fail++;
            $display("FAIL revisit_row got y=%0d done=%b row=%b expected 416,1,0",
                     frog_y, hop_done, new_row);
        end
        hop(4'b0010);
        press(4'b0001);
        tick();
        n_checks++;
        if (frog_y !== 10'd440) begin
            n_fail++;
            $display("FAIL pre_respawn got y=%0d expected 440", frog_y);
        end
        // Respawn coincides with a frame tick and must win.
        @(negedge clk) begin frame_tick = 1'b1; respawn = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; respawn = 1'b0; end
        n_checks++;
        if (frog_x !== 10'd320 || frog_y !== 10'd448 || busy !== 1'b0 || hop_done !== 1'b0) begin
            n_fail++;
            $display("FAIL respawn got %0d,%0d busy=%b done=%b expected 320,448,0,0",
                     frog_x, frog_y, busy, hop_done);
        end
        tick();
        tick();
        n_checks++;
        if (frog_y !== 10'd448 || hop_done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_respawn got y=%0d done=%b expected 448,0", frog_y, hop_done);
        end
        hop(4'b0001);
        n_checks++;
        if (frog_y !== 10'd416 || new_row !== 1'b1) begin
            n_fail++;
            $display("FAIL row_after_respawn got y=%0d row=%b expected 416,1", frog_y, new_row);
        end
    endtask

    task automatic test_reset_mid_hop();
        press(4'b0001);
        tick();
        n_checks++;
        if (frog_y !== 10'd408) begin
            n_fail++;
            $display("FAIL mid_hop_tick1 got y=%0d expected 408", frog_y);
        end
        @(negedge clk) frame_tick = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (frog_x !== 10'd320 || frog_y !== 10'd448 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got %0d,%0d busy=%b expected 320,448,0",
                     frog_x, frog_y, busy);
        end
        @(negedge clk) begin frame_tick = 1'b0; reset = 1'b0; end
    endtask

    task automatic test_priority();
        press(4'b0101);
        n_checks++;
        if (busy !== 1'b1 || facing !== 2'd0) begin
            n_fail++;
            $display("FAIL prio_up_left got busy=%b facing=%0d expected 1,0", busy, facing);
        end
        repeat (4) tick();
        n_checks++;
        if (frog_x !== 10'd320 || frog_y !== 10'd416) begin
            n_fail++;
            $display("FAIL prio_up_pos got %0d,%0d expected 320,416", frog_x, frog_y);
        end
        press(4'b1100);
        repeat (4) tick();
        n_checks++;
        if (frog_x !== 10'd288 || facing !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_left_right got x=%0d facing=%0d expected 288,2", frog_x, facing);
        end
    endtask

    task automatic test_left_bound();
        logic [1:0] exp_facing;
        repeat (9) hop(4'b0100);
        n_checks++;
        if (frog_x !== 10'd0) begin
            n_fail++;
            $display("FAIL walk_left got x=%0d expected 0", frog_x);
        end
        hop(4'b0010);
        press(4'b0100);
`ifdef FROG_WRAP_EN
        exp_facing = 2'd2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_accept got busy=%b expected 1", busy);
        end
        tick();
        n_checks++;
        if (frog_x !== 10'd1016) begin
            n_fail++;
            $display("FAIL wrap_offedge got x=%0d expected 1016", frog_x);
        end
        repeat (3) tick();
        n_checks++;
        if (frog_x !== 10'd608 || hop_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_land got x=%0d done=%b expected 608,1", frog_x, hop_done);
        end
`else
        exp_facing = 2'd1;
        n_checks++;
        if (busy !== 1'b0 || frog_x !== 10'd0) begin
            n_fail++;
            $display("FAIL left_reject got busy=%b x=%0d expected 0,0", busy, frog_x);
        end
        tick();
        n_checks++;
        if (frog_x !== 10'd0 || hop_done !== 1'b0) begin
            n_fail++;
            $display("FAIL left_reject_tick got x=%0d done=%b expected 0,0", frog_x, hop_done);
        end
`endif
        n_checks++;
        if (facing !== exp_facing) begin
            n_fail++;
            $display("FAIL left_facing got %0d expected %0d", facing, exp_facing);
        end
        press(4'b0010);
        n_checks++;
        if (busy !== 1'b0 || frog_y !== 10'd448 || facing !== exp_facing) begin
            n_fail++;
            $display("FAIL down_reject got busy=%b y=%0d facing=%0d expected 0,448,%0d",
                     busy, frog_y, facing, exp_facing);
        end
    endtask

    task automatic test_hold_repeat();
        int hops = 0;
        @(negedge clk) respawn = 1'b1;
        @(negedge clk) respawn = 1'b0;
        @(negedge clk) btn_right = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (hop_done === 1'b1) hops++;
            if (busy === 1'b0) begin
                n_checks++;
                if (frog_x[4:0] !== 5'd0) begin
                    n_fail++;
                    $display("FAIL repeat_grid tick%0d got x=%0d expected multiple of 32",
                             i, frog_x);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (busy !== 1'b0 || frog_x !== 10'd352) begin
                    n_fail++;
                    $display("FAIL repeat_gap got busy=%b x=%0d expected 0,352", busy, frog_x);
                end
            end
        end
        @(negedge clk) btn_right = 1'b0;
        n_checks++;
        if (frog_x !== 10'd448 || busy !== 1'b0 || hops != 4) begin
            n_fail++;
            $display("FAIL repeat_total got x=%0d busy=%b hops=%0d expected 448,0,4",
                     frog_x, busy, hops);
        end
    endtask

    initial begin
        test_reset();
        test_up_hop();
        test_new_row_respawn();
        test_reset_mid_hop();
        test_priority();
        test_left_bound();
        test_hold_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
